// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg: shared state encoding, default width and saturating adder for clk_period_meter
package clk_meas_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int SAT_W = 64;
  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_e;
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a, input logic [SAT_W-1:0] b, input int w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{SAT_W{1'b0}}, 1'b1} << w) - 1'b1;
    return sum > lim ? {1'b1, lim[SAT_W-1:0]} : {1'b0, sum[SAT_W-1:0]};
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-stage input synchronizer with single-cycle rise/fall pulses
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clr,
  input  logic sig_in,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic s, s_d_q, s_d_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    s = sync_q[SYNC_STAGES-1];
    s_d_d = s;
    rise = s & ~s_d_q;
    fall = ~s & s_d_q;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n || clr) begin
      sync_q <= '0;
      s_d_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_d_q <= s_d_d;
    end
  end
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures high time and period of a slow input in clk_in cycles
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT     = 8000000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             overflow,
  output logic             sig_lost
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, high_len_q, high_len_d, period_q, period_d, high_q, high_d;
  logic high_sat_q, high_sat_d, ovf_q, ovf_d, valid_q, valid_d, lost_q, lost_d;
  logic rise, fall, run_sat, timeout, publish;
  logic [SAT_W:0] sum;
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .clr(clr),
    .sig_in(sig_in),
    .rise(rise),
    .fall(fall)
  );
  always_comb begin
    sum = sat_add(SAT_W'(high_len_q), SAT_W'(run_cnt_q), CNT_W);
    run_sat = &run_cnt_q;
    timeout = state_q != WAIT_RISE && !rise && !fall && run_cnt_q == CNT_W'(TIMEOUT);
    publish = state_q == MEAS_LOW && rise;
    run_cnt_d = (rise || fall) ? CNT_W'(1) : run_sat ? run_cnt_q : run_cnt_q + 1'b1;
    state_d = timeout ? WAIT_RISE : rise ? MEAS_HIGH : (fall && state_q == MEAS_HIGH) ? MEAS_LOW : state_q;
    high_len_d = (fall && state_q == MEAS_HIGH) ? run_cnt_q : high_len_q;
    high_sat_d = (fall && state_q == MEAS_HIGH) ? run_sat : high_sat_q;
    period_d = publish ? sum[CNT_W-1:0] : period_q;
    high_d = publish ? high_len_q : high_q;
    ovf_d = publish ? (high_sat_q | run_sat | (|sum[SAT_W:CNT_W])) : ovf_q;
    valid_d = publish;
    lost_d = publish ? 1'b0 : timeout ? 1'b1 : lost_q;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n || clr) begin
      state_q <= WAIT_RISE;
      run_cnt_q <= '0;
      high_len_q <= '0;
      high_sat_q <= 1'b0;
      period_q <= '0;
      high_q <= '0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_cnt_q <= run_cnt_d;
      high_len_q <= high_len_d;
      high_sat_q <= high_sat_d;
      period_q <= period_d;
      high_q <= high_d;
      ovf_q <= ovf_d;
      valid_q <= valid_d;
      lost_q <= lost_d;
    end
  end
  assign period_out = period_q;
  assign high_out = high_q;
  assign meas_valid = valid_q;
  assign overflow = ovf_q;
  assign sig_lost = lost_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed scoreboard bench for clk_period_meter
module tb_clk_period_meter;
  import clk_meas_pkg::*;
  typedef struct {
    logic [31:0] p;
    logic [31:0] h;
    logic        o;
    int          gap;
  } exp_t;
  logic clk_in = 1'b0;
  logic rst_n, sig_in, clr, sat_sig;
  logic [31:0] period_out, high_out;
  logic meas_valid, overflow, sig_lost;
  logic [7:0] sat_period, sat_high;
  logic sat_valid, sat_ovf, sat_lost, sat_clr;
  int checks = 0, errors = 0;
  int cyc = 0, last_cyc = 0;
  exp_t sb[$];
  exp_t sat_sb[$];
  always #5 clk_in = ~clk_in;
  clk_period_meter #(.CNT_W(32), .TIMEOUT(100), .SYNC_STAGES(2)) u_dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .clr(clr),
    .period_out(period_out),
    .high_out(high_out),
    .meas_valid(meas_valid),
    .overflow(overflow),
    .sig_lost(sig_lost)
  );
  clk_period_meter #(.CNT_W(8), .TIMEOUT(254), .SYNC_STAGES(2)) u_sat (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .sig_in(sat_sig),
    .clr(sat_clr),
    .period_out(sat_period),
    .high_out(sat_high),
    .meas_valid(sat_valid),
    .overflow(sat_ovf),
    .sig_lost(sat_lost)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_n(int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic hl(int h, int l, bit pe, int ep, int eh, int gap);
    if (pe) sb.push_back('{ep, eh, 1'b0, gap});
    sig_in = 1'b1;
    wait_n(h);
    sig_in = 1'b0;
    wait_n(l);
  endtask
  always @(negedge clk_in) begin
    exp_t e;
    cyc++;
    if (meas_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_publish", 32'(meas_valid), 0);
      else begin
        e = sb.pop_front();
        check("period", period_out, e.p);
        check("high", high_out, e.h);
        check("overflow", 32'(overflow), 32'(e.o));
        if (e.gap != 0) check("publish_gap", cyc - last_cyc, e.gap);
      end
      last_cyc = cyc;
    end
  end
  always @(negedge clk_in) begin
    exp_t e;
    if (sat_valid === 1'b1) begin
      if (sat_sb.size() == 0) check("sat_unexpected_publish", 32'(sat_valid), 0);
      else begin
        e = sat_sb.pop_front();
        check("sat_period", 32'(sat_period), e.p);
        check("sat_high", 32'(sat_high), e.h);
        check("sat_overflow", 32'(sat_ovf), 32'(e.o));
      end
    end
  end
  initial begin
    int n;
    rst_n = 1'b0;
    sig_in = 1'b0;
    clr = 1'b0;
    sat_clr = 1'b0;
    sat_sig = 1'b0;
    repeat (5) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check("rst_period", period_out, 0);
      check("rst_high", high_out, 0);
      check("rst_valid", 32'(meas_valid), 0);
      check("rst_flags", {30'd0, overflow, sig_lost}, 0);
      sig_in = ~sig_in;
    end
    sig_in = 1'b0;
    rst_n = 1'b1;
    wait_n(5);
    hl(31, 31, 1'b0, 0, 0, 0);
    hl(31, 31, 1'b1, 62, 31, 0);
    repeat (3) hl(31, 31, 1'b1, 62, 31, 62);
    hl(10, 5, 1'b1, 62, 31, 62);
    hl(10, 5, 1'b1, 15, 10, 15);
    hl(10, 5, 1'b1, 15, 10, 15);
    hl(3, 5, 1'b1, 15, 10, 15);
    hl(3, 3, 1'b1, 8, 3, 8);
    hl(3, 3, 1'b1, 6, 3, 6);
    hl(3, 3, 1'b1, 6, 3, 6);
    sb.push_back('{6, 3, 1'b0, 6});
    sig_in = 1'b1;
    n = 0;
    while (meas_valid !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    check("tmo_publish_seen", 32'(meas_valid), 1);
    wait_n(99);
    check("tmo_not_early", 32'(sig_lost), 0);
    wait_n(1);
    check("tmo_lost", 32'(sig_lost), 1);
    check("tmo_state", 32'(u_dut.state_q), 32'(WAIT_RISE));
    check("tmo_period_hold", period_out, 6);
    check("tmo_high_hold", high_out, 3);
    check("tmo_no_valid", 32'(meas_valid), 0);
    wait_n(50);
    sig_in = 1'b0;
    wait_n(20);
    hl(5, 5, 1'b0, 0, 0, 0);
    check("lost_held", 32'(sig_lost), 1);
    hl(5, 5, 1'b1, 10, 5, 0);
    check("lost_cleared", 32'(sig_lost), 0);
    sb.push_back('{10, 5, 1'b0, 10});
    sig_in = 1'b1;
    wait_n(5);
    sig_in = 1'b0;
    wait_n(6);
    check("clr_pre_state", 32'(u_dut.state_q), 32'(MEAS_LOW));
    clr = 1'b1;
    wait_n(1);
    clr = 1'b0;
    check("clr_period", period_out, 0);
    check("clr_high", high_out, 0);
    check("clr_flags", {30'd0, overflow, sig_lost}, 0);
    check("clr_state", 32'(u_dut.state_q), 32'(WAIT_RISE));
    wait_n(4);
    hl(5, 5, 1'b0, 0, 0, 0);
    hl(5, 5, 1'b1, 10, 5, 0);
    wait_n(5);
    check("sb_drained", sb.size(), 0);
    sat_sig = 1'b1;
    wait_n(200);
    sat_sig = 1'b0;
    wait_n(200);
    sat_sb.push_back('{255, 200, 1'b1, 0});
    sat_sig = 1'b1;
    n = 0;
    while (sat_valid !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check("sat_publish_seen", 32'(sat_valid), 1);
    check("sat_no_timeout", 32'(sat_lost), 0);
    wait_n(5);
    check("sat_sb_drained", sat_sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
